// File: rtl/seq_tx.sv
// Serial pattern transmitter: latches PATTERN on START and shifts it out MSB-first,
// with REPS repeated frames and GAP_CYC idle cycles between frames. Optional macro SEQ_TX_PARITY_EN.
module seq_tx #(
  parameter int WIDTH   = 8,
  parameter int LEN_W   = 4,
  parameter int REP_W   = 4,
  parameter int GAP_CYC = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] PATTERN,
  input  logic [LEN_W-1:0] LEN,
  input  logic [REP_W-1:0] REPS,
  output logic             OUT,
  output logic             BUSY,
  output logic             DONE
);

  localparam int GW = $clog2(GAP_CYC + 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SHIFT  = 3'd1;
  localparam logic [2:0] S_GAP    = 3'd2;
  localparam logic [2:0] S_FINISH = 3'd3;
`ifdef SEQ_TX_PARITY_EN
  localparam logic [2:0] S_PAR    = 3'd4;
`endif

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d, sh_q, sh_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             out_q, out_d;
`ifdef SEQ_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  logic [LEN_W-1:0] lenc, shamt;
  logic [WIDTH-1:0] aligned;
  logic             frame_end;

  // Pattern is stored left-aligned so the first bit to send is always the MSB.
  assign lenc    = (LEN > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : LEN;
  assign shamt   = LEN_W'(WIDTH) - lenc;
  assign aligned = PATTERN << shamt;

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    sh_d      = sh_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    rep_d     = rep_q;
    gap_d     = gap_q;
    out_d     = 1'b0;
    frame_end = 1'b0;
`ifdef SEQ_TX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (START && (LEN != '0)) begin
          state_d = S_SHIFT;
          pat_d   = aligned;
          sh_d    = aligned << 1;
          len_d   = lenc;
          cnt_d   = lenc - LEN_W'(1);
          rep_d   = (REPS == '0) ? REP_W'(1) : REPS;
          out_d   = aligned[WIDTH-1];
`ifdef SEQ_TX_PARITY_EN
          par_d   = ^aligned;
`endif
        end
      end
      S_SHIFT: begin
        if (cnt_q != '0) begin
          out_d = sh_q[WIDTH-1];
          sh_d  = sh_q << 1;
          cnt_d = cnt_q - LEN_W'(1);
        end else begin
`ifdef SEQ_TX_PARITY_EN
          state_d = S_PAR;
          out_d   = par_q;
`else
          frame_end = 1'b1;
`endif
        end
      end
`ifdef SEQ_TX_PARITY_EN
      S_PAR: frame_end = 1'b1;
`endif
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_SHIFT;
          out_d   = pat_q[WIDTH-1];
          sh_d    = pat_q << 1;
          cnt_d   = len_q - LEN_W'(1);
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // rep_q counts frames still owed, including the one just finished.
    if (frame_end) begin
      if (rep_q > REP_W'(1)) begin
        rep_d = rep_q - REP_W'(1);
        if (GAP_CYC > 0) begin
          state_d = S_GAP;
          gap_d   = GW'(GAP_CYC - 1);
        end else begin
          state_d = S_SHIFT;
          out_d   = pat_q[WIDTH-1];
          sh_d    = pat_q << 1;
          cnt_d   = len_q - LEN_W'(1);
        end
      end else begin
        state_d = S_FINISH;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      sh_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      out_q   <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      sh_q    <= sh_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      out_q   <= out_d;
`ifdef SEQ_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign OUT = out_q;
`ifdef SEQ_TX_PARITY_EN
  assign BUSY = (state_q == S_SHIFT) || (state_q == S_GAP) || (state_q == S_PAR);
`else
  assign BUSY = (state_q == S_SHIFT) || (state_q == S_GAP);
`endif
  assign DONE = (state_q == S_FINISH);

endmodule

// File: doc/seq_tx.md
Name: seq_tx

Overview:
- Serial pattern transmitter: the sending end of the single-bit sequence-detector interface (CLK/RST/IN/MATCH).
- Latches a parallel pattern on START and shifts it out MSB-first on OUT, one bit per clock.
- Frames can repeat with a configurable idle gap between them. DONE pulses when the whole burst is finished.
- Used to drive the IN input of detector FSMs and as a reusable stimulus source.

Parameters:
- WIDTH, 8, maximum pattern length in bits.
- LEN_W, 4, width of LEN port; must satisfy 2^LEN_W > WIDTH.
- REP_W, 4, width of REPS port.
- GAP_CYC, 2, idle cycles (OUT=0) between repeated frames; 0 = back-to-back frames.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  request; sampled only in IDLE.
- PATTERN  input  WIDTH  bits to send; bit LEN-1 is sent first, bit 0 last.
- LEN  input  LEN_W  frame length in bits.
- REPS  input  REP_W  number of frames to send; 0 is treated as 1.
- OUT  output  1  registered serial bit.
- BUSY  output  1  high while a burst is in progress.
- DONE  output  1  one-cycle completion pulse.

Behaviour:
- Reset: one clock is synchronous and RST is synchronous active-high. On an edge with RST=1: state=IDLE, OUT=0, BUSY=0, DONE=0, all counters and shadow registers cleared. RST has priority over everything else, including mid-frame; the aborted frame is not resumed and DONE does not pulse.
- States: IDLE, SHIFT, GAP, FINISH.
- IDLE (OUT=0, BUSY=0, DONE=0):
  - On an edge with START=1 and LEN!=0: latch PATTERN, latch LEN (values >WIDTH clamp to WIDTH), latch REPS (0→1); go to SHIFT.
  - START with LEN==0 is ignored and the block stays in IDLE.
- SHIFT (BUSY=1):
  - OUT carries pattern bit index LEN-1 down to 0, one bit per cycle.
  - The first bit is visible in the cycle after the START edge, so latency is 1 cycle.
  - After bit 0, with frames remaining: GAP if GAP_CYC>0, else directly SHIFT (next frame, bit LEN-1, no idle cycle).
  - After bit 0 of the last frame: FINISH.
- GAP (BUSY=1, OUT=0): exactly GAP_CYC cycles, then SHIFT for the next frame.
- FINISH (BUSY=0, OUT=0, DONE=1): exactly one cycle, then IDLE.
- START is ignored whenever state!=IDLE (SHIFT, GAP, FINISH). It does not queue, and PATTERN/LEN/REPS changes during a burst have no effect.
- Burst length in cycles = REPS*LEN + (REPS-1)*GAP_CYC, followed by one DONE cycle.
- LEN==1: each frame is a single bit; repetition rules are unchanged.
- A new START is accepted at the earliest in the IDLE cycle following FINISH.

Optional Feature:
- Macro: SEQ_TX_PARITY_EN.
- Defined:
  - Each frame gets one extra bit after bit 0: the even-parity bit, i.e. the XOR of the LEN transmitted bits.
  - BUSY stays high during the parity bit.
  - Effective frame length is LEN+1 in every timing rule above.
- Undefined: no parity bit and no parity logic; frame length is LEN.

Test Plan:
- Basic frame: RST held 3 cycles, then START=1 for one cycle with PATTERN=8'h8B, LEN=8, REPS=1, GAP_CYC=2. Required: OUT = 1,0,0,0,1,0,1,1 on cycles k+1..k+8 after the START edge k; BUSY=1 on exactly those cycles; DONE=1 only on k+9; IDLE with OUT=0 from k+10.
- Repeat with gap: PATTERN=3'b101, LEN=3, REPS=2, GAP_CYC=2. Required: OUT = 1,0,1,0,0,1,0,1, then one DONE cycle. Repeat with GAP_CYC=0: OUT = 1,0,1,1,0,1.
- Ignored requests:
  - START with LEN=0: BUSY stays 0, no DONE.
  - Second START issued mid-burst with a different PATTERN: no change to the OUT sequence, and exactly one DONE.
  - REPS=0 behaves identically to REPS=1.
- Reset mid-frame: assert RST during bit 4 of PATTERN=8'hFF, LEN=8. Required: next edge gives OUT=0, BUSY=0; no DONE ever follows; a fresh START afterwards transmits the complete frame normally.
- Parity (SEQ_TX_PARITY_EN defined): PATTERN=3'b111, LEN=3 gives OUT = 1,1,1,1; PATTERN=3'b110 gives OUT = 1,1,0,0; DONE one cycle after the parity bit. With the macro undefined, the same stimuli give 3-bit frames.
- Detector loopback: OUT drives the sequence-detector FSM's IN. Send the detector's target pattern and require MATCH=1 at the detector's documented latency after the last bit. Send the pattern with one bit flipped and require that MATCH never asserts.
